// File: rtl/led_status_overlay.sv
// LED output stage: passes the breathe PWM vector through, blinks event codes
// on handshake, and shows an alternating error pattern while an error is latched.
module led_status_overlay #(
  parameter int unsigned LED_WIDTH   = 8,
  parameter int unsigned CLKS_PER_MS = 50000,
  parameter int unsigned BLINK_MS    = 100,
  parameter int unsigned BLINK_COUNT = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [LED_WIDTH-1:0] breathe_data,
  input  logic                 evt_valid,
  input  logic [LED_WIDTH-1:0] evt_code,
  output logic                 evt_ready,
  input  logic                 err_flag,
  input  logic                 err_clr,
  output logic [LED_WIDTH-1:0] led_data,
  output logic                 busy
);

  localparam int unsigned TICK_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;

  localparam logic [TICK_W-1:0] TICK_MAX  = TICK_W'(CLKS_PER_MS - 1);
  localparam logic [15:0]       MS_MAX    = 16'(BLINK_MS - 1);
  localparam logic [7:0]        BLINK_TGT = 8'(BLINK_COUNT);

  function automatic logic [LED_WIDTH-1:0] alt_pattern();
    logic [LED_WIDTH-1:0] p;
    p = '0;
    for (int unsigned i = 0; i < LED_WIDTH; i++) begin
      p[i] = (i % 2 == 0);
    end
    return p;
  endfunction

  localparam logic [LED_WIDTH-1:0] ALT_PAT = alt_pattern();

  typedef enum logic [1:0] {
    S_PASS  = 2'd0,
    S_ON    = 2'd1,
    S_OFF   = 2'd2,
    S_ERROR = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
  logic [15:0]          ms_cnt_q, ms_cnt_d;
  logic [7:0]           blink_cnt_q, blink_cnt_d;
  logic [7:0]           blink_inc;
  logic [LED_WIDTH-1:0] code_q, code_d;
  logic [LED_WIDTH-1:0] pat_q, pat_d;
  logic [LED_WIDTH-1:0] led_q, led_d;
  logic                 err_q, err_d;
  logic                 tick;
  logic                 phase_done;

  assign tick       = (tick_cnt_q == TICK_MAX);
  assign phase_done = tick && (ms_cnt_q == MS_MAX);
  assign blink_inc  = blink_cnt_q + 8'd1;

  // An error asserted this cycle must also block the handshake, hence err_flag here.
  assign evt_ready = (state_q == S_PASS) && !err_flag;
  assign busy      = (state_q != S_PASS);
  assign led_data  = led_q;

  always_comb begin
    state_d     = state_q;
    led_d       = led_q;
    code_d      = code_q;
    blink_cnt_d = blink_cnt_q;
    pat_d       = pat_q;
    err_d       = err_flag | (err_q & ~err_clr);

    unique case (state_q)
      S_PASS: begin
        led_d = breathe_data;
        if (evt_valid && evt_ready) begin
          code_d      = evt_code;
          blink_cnt_d = '0;
          state_d     = S_ON;
        end
      end
      S_ON: begin
        led_d = code_q;
        if (phase_done) state_d = S_OFF;
      end
      S_OFF: begin
        led_d = '0;
        if (phase_done) begin
          blink_cnt_d = blink_inc;
          state_d     = (blink_inc == BLINK_TGT) ? S_PASS : S_ON;
        end
      end
      S_ERROR: begin
        led_d = pat_q;
        if (phase_done) pat_d = ~pat_q;
        if (!err_d) state_d = S_PASS;
      end
      default: state_d = S_PASS;
    endcase

    // Error overrides every state; entering it aborts any blink sequence.
    if (err_d) begin
      state_d = S_ERROR;
      if (state_q != S_ERROR) begin
        blink_cnt_d = '0;
        code_d      = '0;
        pat_d       = ALT_PAT;
      end
    end
  end

  always_comb begin
    tick_cnt_d = tick_cnt_q;
    ms_cnt_d   = ms_cnt_q;
    if (state_d != state_q) begin
      tick_cnt_d = '0;
      ms_cnt_d   = '0;
    end else if (tick) begin
      tick_cnt_d = '0;
      ms_cnt_d   = phase_done ? '0 : ms_cnt_q + 16'd1;
    end else begin
      tick_cnt_d = tick_cnt_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PASS;
      tick_cnt_q  <= '0;
      ms_cnt_q    <= '0;
      blink_cnt_q <= '0;
      code_q      <= '0;
      pat_q       <= '0;
      led_q       <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_cnt_q  <= tick_cnt_d;
      ms_cnt_q    <= ms_cnt_d;
      blink_cnt_q <= blink_cnt_d;
      code_q      <= code_d;
      pat_q       <= pat_d;
      led_q       <= led_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_led_status_overlay.sv
// Randomized self-checking bench for led_status_overlay against a
// time-based behavioural model of the blink/error display.
module tb_led_status_overlay;

  localparam int W   = 8;
  localparam int CPM = 10;
  localparam int BMS = 2;
  localparam int BC  = 3;
  localparam int P   = CPM * BMS;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [W-1:0] breathe_data;
  logic         evt_valid;
  logic [W-1:0] evt_code;
  logic         evt_ready;
  logic         err_flag;
  logic         err_clr;
  logic [W-1:0] led_data;
  logic         busy;

  led_status_overlay #(
    .LED_WIDTH  (W),
    .CLKS_PER_MS(CPM),
    .BLINK_MS   (BMS),
    .BLINK_COUNT(BC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .breathe_data(breathe_data),
    .evt_valid   (evt_valid),
    .evt_code    (evt_code),
    .evt_ready   (evt_ready),
    .err_flag    (err_flag),
    .err_clr     (err_clr),
    .led_data    (led_data),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: mode 0 = passthrough, 1 = blinking, 2 = error; m_t = cycles since mode entry.
  int           m_mode;
  int           m_t;
  logic [W-1:0] m_code;
  logic [W-1:0] m_led;
  logic         m_err;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0;
    m_t    = 0;
    m_code = '0;
    m_led  = '0;
    m_err  = 1'b0;
  endtask

  task automatic model_step();
    logic         err_n;
    logic [W-1:0] led_n;
    err_n = err_flag | (m_err & ~err_clr);
    case (m_mode)
      0:       led_n = breathe_data;
      1:       led_n = ((m_t / P) % 2 == 0) ? m_code : '0;
      default: led_n = ((m_t / P) % 2 == 0) ? 8'h55 : 8'hAA;
    endcase
    if (err_n) begin
      if (m_mode != 2) begin m_mode = 2; m_t = 0; end
      else m_t++;
    end else if (m_mode == 2) begin
      m_mode = 0; m_t = 0;
    end else if (m_mode == 0) begin
      if (evt_valid) begin m_mode = 1; m_t = 0; m_code = evt_code; end
    end else begin
      if (m_t == 2 * P * BC - 1) begin m_mode = 0; m_t = 0; end
      else m_t++;
    end
    m_err = err_n;
    m_led = led_n;
  endtask

  // One clock: check outputs mid-cycle, advance model, return just after the edge.
  task automatic cycle();
    @(negedge clk);
    check_eq("led_data", led_data, m_led);
    check_eq("busy", busy, m_mode != 0);
    check_eq("evt_ready", evt_ready, (m_mode == 0) && !err_flag);
    model_step();
    @(posedge clk);
    #1;
    breathe_data = W'($urandom);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n        = 1'b0;
    breathe_data = '0;
    evt_valid    = 1'b0;
    evt_code     = '0;
    err_flag     = 1'b0;
    err_clr      = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_led", led_data, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_ready", evt_ready, 1);
    rst_n = 1'b1;

    // Passthrough
    breathe_data = 8'hA5;
    cycle();
    check_eq("pass_a5", led_data, 8'hA5);
    run(5);

    // Single-cycle event, full sequence
    evt_code  = 8'h3C;
    evt_valid = 1'b1;
    cycle();
    evt_valid = 1'b0;
    evt_code  = 8'h00;
    run(2 * P * BC + 5);

    // Event held while busy: accepted only at first ready cycle
    evt_code  = 8'h11;
    evt_valid = 1'b1;
    cycle();
    evt_code = 8'hFF;
    run(10);
    check_eq("held_busy", busy, 1);
    run(2 * P * BC);
    evt_valid = 1'b0;
    run(2 * P * BC + 5);

    // Error during second ON phase
    evt_code  = 8'h3C;
    evt_valid = 1'b1;
    cycle();
    evt_valid = 1'b0;
    run(2 * P + 5);
    err_flag = 1'b1;
    cycle();
    err_flag = 1'b0;
    cycle();
    check_eq("err_first", led_data, 8'h55);
    run(P + 10);

    // Simultaneous set/clear stays in error, then clear alone returns to pass
    err_flag = 1'b1;
    err_clr  = 1'b1;
    cycle();
    err_flag = 1'b0;
    run(1);
    check_eq("clr_done", busy, 0);
    err_clr = 1'b0;
    run(P * 2 * BC + 3);

    // Error with simultaneous event offer
    evt_code  = 8'h99;
    evt_valid = 1'b1;
    err_flag  = 1'b1;
    cycle();
    evt_valid = 1'b0;
    err_flag  = 1'b0;
    run(3);
    err_clr = 1'b1;
    cycle();
    err_clr = 1'b0;
    run(5);

    // Reset mid OFF phase
    evt_code  = 8'hC3;
    evt_valid = 1'b1;
    cycle();
    evt_valid = 1'b0;
    run(P + 5);
    rst_n = 1'b0;
    #2;
    check_eq("rst_led", led_data, 0);
    check_eq("rst_busy", busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run(2 * P * BC + 5);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      if (!evt_valid || ($urandom_range(0, 3) == 0)) evt_valid = ($urandom_range(0, 7) == 0);
      evt_code = W'($urandom);
      err_flag = ($urandom_range(0, 299) == 0);
      err_clr  = ($urandom_range(0, 19) == 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
